// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter on the
// display path: key width, digit count and FSM encoding.
package bin2bcd_seq_pkg;

  // Key width shown on the display and the number of BCD digits it needs.
  localparam int unsigned KEY_W      = 32;
  localparam int unsigned BCD_DIGITS = 10;

  // Converter FSM: waiting for a request, or running shift-add-3 iterations.
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
// The sum stays within 4 bits because 9 + 3 = 12 (4'hC).
module bin2bcd_seq_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// One bit of the binary input is consumed per cycle, so a conversion takes
// BIN_W cycles in CONV. The result register only changes on the final
// iteration, so the display never shows a partial value.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W        = KEY_W,
  parameter int unsigned DIGITS       = BCD_DIGITS,
  parameter bit          AUTO_REFRESH = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sh_bin_q, sh_bin_d;
  logic [BIN_W-1:0]   last_bin_q, last_bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_sh;
  logic [BIN_W-1:0]   sh_bin_sh;
  logic               req;

  // Per-digit +3 correction applied to the current scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_seq_digit_adj u_adj (
      .dig_i (scratch_q[4*g +: 4]),
      .dig_o (scratch_adj[4*g +: 4])
    );
  end

  // {scratch, sh_bin} shifted left by one after correction.
  assign scratch_sh = {scratch_adj[BCD_W-2:0], sh_bin_q[BIN_W-1]};
  assign sh_bin_sh  = {sh_bin_q[BIN_W-2:0], 1'b0};

  // A new conversion is wanted on an explicit start, or when the shown
  // value differs from the one last converted (auto-refresh builds only).
  assign req = start_i | (AUTO_REFRESH & (bin_i != last_bin_q));

  // Next-state logic: latch on request in IDLE, iterate in CONV, publish
  // the result and pulse done on the last iteration.
  always_comb begin
    state_d    = state_q;
    sh_bin_d   = sh_bin_q;
    last_bin_d = last_bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          sh_bin_d   = bin_i;
          last_bin_d = bin_i;
          scratch_d  = '0;
          cnt_d      = '0;
          state_d    = CONV;
        end
      end
      CONV: begin
        scratch_d = scratch_sh;
        sh_bin_d  = sh_bin_sh;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bcd_d   = scratch_sh;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any conversion in flight and clears the result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sh_bin_q   <= '0;
      last_bin_q <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_bin_q   <= sh_bin_d;
      last_bin_q <= last_bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (state_q == CONV);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes the expected BCD for
// each conversion it causes, a monitor pops and compares on every done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bin = 32'd1234;
  logic        busy, done;
  logic [39:0] bcd;

  logic        start0 = 1'b0;
  logic [31:0] bin0 = 32'd0;
  logic        busy0, done0;
  logic [39:0] bcd0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [39:0] exp_q[$];
  int unsigned busy_run = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10), .AUTO_REFRESH(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bin_i(bin),
    .busy_o(busy), .done_o(done), .bcd_o(bcd)
  );

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10), .AUTO_REFRESH(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .bin_i(bin0),
    .busy_o(busy0), .done_o(done0), .bcd_o(bcd0)
  );

  // Reference: decimal digits by repeated division.
  function automatic logic [39:0] bcd_of(input logic [31:0] v);
    logic [39:0] r;
    longint unsigned x;
    r = '0;
    x = longint'(v);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every done must match the oldest outstanding expectation,
  // and every completed busy window must last exactly 32 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else chk("bcd", 64'(bcd), 64'(exp_q.pop_front()));
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", 64'(busy_run), 64'd32);
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic start_conv(input logic [31:0] v);
    wait_idle();
    bin = v;
    start = 1'b1;
    exp_q.push_back(bcd_of(v));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Counts negedges until done, starting from the edge where the request was set.
  task automatic wait_done_lat(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 60);
  endtask

  initial begin
    #400_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [39:0] held;
    logic moved;
    logic [31:0] rv;

    // 1: reset state, then auto-refresh picks up bin=1234.
    repeat (3) @(negedge clk);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    exp_q.push_back(bcd_of(32'd1234));
    rst_n = 1'b1;
    wait_done_lat(lat);
    chk("auto_lat", 64'(lat), 64'd33);
    drain();
    chk("bcd_1234", 64'(bcd), 64'h0000001234);

    // 2: maximum input, latency measured from the start pulse.
    wait_idle();
    bin = 32'hFFFF_FFFF;
    start = 1'b1;
    exp_q.push_back(bcd_of(bin));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done_lat(lat);
    chk("start_lat", 64'(lat), 64'd33);
    drain();
    chk("bcd_max", 64'(bcd), 64'h4294967295);

    // 3: zero, then stability when idle with unchanged bin.
    start_conv(32'd0);
    drain();
    held = bcd;
    moved = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || bcd !== held) moved = 1'b1;
    end
    chk("idle_stable", 64'(moved), 64'd0);

    // 3b: no auto-refresh build ignores bin changes until started.
    bin0 = 32'd7;
    moved = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy0 || done0) moved = 1'b1;
    end
    chk("noauto_quiet", 64'(moved), 64'd0);
    chk("noauto_bcd0", 64'(bcd0), 64'd0);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done0 && n < 60);
    chk("noauto_lat", 64'(n), 64'd33);
    chk("noauto_bcd7", 64'(bcd0), 64'(bcd_of(32'd7)));

    // 4: bin change + start while busy is ignored, then auto-refresh converts it.
    start_conv(32'd100);
    repeat (9) @(negedge clk);
    bin = 32'd999;
    start = 1'b1;
    exp_q.push_back(bcd_of(32'd999));
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    chk("bcd_999", 64'(bcd), 64'h999);

    // 5: start in the done cycle is accepted back-to-back.
    start_conv(32'd4242);
    start_conv(32'd65535);
    chk("b2b_busy", 64'(busy), 64'd1);
    drain();
    chk("bcd_65535", 64'(bcd), 64'h0000065535);

    // 6: reset mid-conversion aborts with no done, auto-refresh restarts after.
    wait_idle();
    bin = 32'd123456789;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(bcd_of(32'd123456789));
    rst_n = 1'b1;
    drain();
    chk("bcd_123456789", 64'(bcd), 64'h0123456789);

    // Random sweep, mixing extremes and small values with full-range words.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       rv = 32'd0;
        1:       rv = 32'hFFFF_FFFF;
        2:       rv = $urandom_range(0, 999);
        3:       rv = 32'd1 << $urandom_range(0, 31);
        default: rv = $urandom;
      endcase
      start_conv(rv);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
